// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS symbol constants, TERC4 lookup and popcount helper.
// Used by tmds_qm_stage and tmds_channel_encoder (TERC4 only with TMDS_TERC4_EN).
package tmds_pkg;

    localparam logic [9:0] CTRL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [9:0] terc4(input logic [3:0] aux);
        return TERC4_SYM[aux];
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++)
            c = c + 4'(d[i]);
        return c;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// tmds_channel_encoder_if: pixel-side inputs and symbol output of one TMDS lane.
// TMDS_TERC4_EN adds the data-island inputs i_island/i_aux.
interface tmds_channel_encoder_if;
    logic       i_de;
    logic [7:0] i_data;
    logic [1:0] i_ctrl;
    logic [9:0] q_out;
`ifdef TMDS_TERC4_EN
    logic       i_island;
    logic [3:0] i_aux;
    modport master (output i_de, i_data, i_ctrl, i_island, i_aux, input q_out);
    modport slave  (input i_de, i_data, i_ctrl, i_island, i_aux, output q_out);
`else
    modport master (output i_de, i_data, i_ctrl, input q_out);
    modport slave  (input i_de, i_data, i_ctrl, output q_out);
`endif
endinterface

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: transition-minimising first stage (byte -> q_m[8:0]) plus
// the ones/zeros count of q_m[7:0] needed by the DC-balance stage.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m,
    output logic [3:0] n1q,
    output logic [3:0] n0q
);

    logic [3:0] n1d;
    logic       use_xnor;

    // XNOR chaining is the XOR chain with every stage inverted.
    function automatic logic [7:0] chain(input logic [7:0] d, input logic inv);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = q[i-1] ^ d[i] ^ inv;
        return q;
    endfunction

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !data[0]);
        q_m      = {!use_xnor, chain(data, use_xnor)};
        n1q      = popcount8(q_m[7:0]);
        n0q      = 4'd8 - n1q;
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: DVI/HDMI TMDS 8b/10b encoder for one colour channel.
// Define TMDS_TERC4_EN to add HDMI data-island TERC4 encoding.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                  i_pixclk,
    input  logic                  i_reset,
    tmds_channel_encoder_if.slave bus
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [8:0]              q_m;
    logic [3:0]              n1q, n0q;
    logic [9:0]              sym, ctrl_sym;
    logic signed [CNT_W-1:0] cnt, cnt_nx, bal;

    tmds_qm_stage u_qm (.data(bus.i_data), .q_m(q_m), .n1q(n1q), .n0q(n0q));

    assign bal = CNT_W'(n1q) - CNT_W'(n0q);

`ifdef TMDS_TERC4_EN
    assign ctrl_sym = bus.i_island ? terc4(bus.i_aux) : CTRL_SYM[bus.i_ctrl];
`else
    assign ctrl_sym = CTRL_SYM[bus.i_ctrl];
`endif

    // Default branch: send q_m as-is; the others invert to steer disparity back to 0.
    always_comb begin
        sym    = {1'b0, q_m[8], q_m[7:0]};
        cnt_nx = cnt + bal - (q_m[8] ? '0 : TWO);
        if (!bus.i_de) begin
            sym    = ctrl_sym;
            cnt_nx = '0;
        end else if (cnt == 0 || bal == 0) begin
            sym    = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_nx = q_m[8] ? cnt + bal : cnt - bal;
        end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
            sym    = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_nx = cnt - bal + (q_m[8] ? TWO : '0);
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset) begin
        if (!i_reset) begin
            bus.q_out <= '0;
            cnt       <= '0;
        end else begin
            bus.q_out <= sym;
            cnt       <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed vector table, reset corners and a
// randomized run against a reference model of the TMDS encoding rules.
module tb_tmds_channel_encoder;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [9:0] q;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0;
    logic [7:0] data = '0;
    logic [1:0] ctrl = '0;
    logic       island = 1'b0;
    logic [3:0] aux = '0;
    int         tests = 0;
    int         fails = 0;
    int         m_cnt = 0;
    int         rd = 0;
    logic [9:0] exp_q;
    vec_t       vecs [11];

    logic [9:0] tb_ctrl [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] tb_terc [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    tmds_channel_encoder_if bus ();

    assign bus.i_de   = de;
    assign bus.i_data = data;
    assign bus.i_ctrl = ctrl;
`ifdef TMDS_TERC4_EN
    assign bus.i_island = island;
    assign bus.i_aux    = aux;
`endif

    tmds_channel_encoder #(.CNT_W(5)) dut (.i_pixclk(clk), .i_reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick XOR/XNOR by ones count, then invert or not to pull
    // the running disparity (tracked as an int) toward zero.
    task automatic model_step(output logic [9:0] sym);
        int         n1d, bal;
        logic       xn;
        logic [8:0] qm;
        if (!de) begin
            m_cnt = 0;
            sym = island ? tb_terc[aux] : tb_ctrl[ctrl];
        end else begin
            n1d = $countones(data);
            xn = n1d > 4 || (n1d == 4 && !data[0]);
            qm[0] = data[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
            qm[8] = !xn;
            bal = 2 * $countones(qm[7:0]) - 8;
            if (m_cnt == 0 || bal == 0) begin
                sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt += qm[8] ? bal : -bal;
            end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
                sym = {1'b1, qm[8], ~qm[7:0]};
                m_cnt += (qm[8] ? 2 : 0) - bal;
            end else begin
                sym = {1'b0, qm[8], qm[7:0]};
                m_cnt += bal - (qm[8] ? 0 : 2);
            end
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] v, d;
        v = s[9] ? ~s[7:0] : s[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++)
            d[i] = v[i] ^ v[i-1] ^ ~s[8];
        return d;
    endfunction

    initial begin
        vecs = '{
            '{1'b1, 8'h57, 2'b00, 10'h298},
            '{1'b1, 8'h57, 2'b00, 10'h067},
            '{1'b1, 8'h57, 2'b00, 10'h067},
            '{1'b0, 8'h00, 2'b00, 10'h354},
            '{1'b1, 8'h00, 2'b00, 10'h100},
            '{1'b1, 8'h00, 2'b00, 10'h3FF},
            '{1'b0, 8'hA5, 2'b01, 10'h0AB},
            '{1'b0, 8'hFF, 2'b10, 10'h154},
            '{1'b0, 8'h3C, 2'b11, 10'h2AB},
            '{1'b1, 8'h00, 2'b00, 10'h100},
            '{1'b1, 8'h00, 2'b00, 10'h3FF}
        };

        // Reset held with random inputs, then release into a control period.
        for (int i = 0; i < 3; i++) begin
            de = 1'($urandom); data = 8'($urandom); ctrl = 2'($urandom);
            tick();
            check("reset_hold", bus.q_out, 10'h000);
        end
        de = 1'b0; ctrl = 2'b10; rst_n = 1'b1;
        #1 check("post_release_pre_edge", bus.q_out, 10'h000);
        tick();
        check("first_ctrl", bus.q_out, 10'h154);
        tick();
        check("ctrl_held", bus.q_out, 10'h154);

        for (int i = 0; i < 11; i++) begin
            de = vecs[i].de; data = vecs[i].data; ctrl = vecs[i].ctrl;
            tick();
            check($sformatf("vec%0d", i), bus.q_out, vecs[i].q);
        end

        // Async reset mid-stream: output clears at once and disparity restarts at 0.
        de = 1'b1; data = 8'h00;
        tick();
        check("pre_reset_sym", bus.q_out, 10'h100);
        #2 rst_n = 1'b0;
        #1 check("async_clear", bus.q_out, 10'h000);
        tick();
        rst_n = 1'b1;
        tick();
        check("cnt_cleared", bus.q_out, 10'h100);

`ifdef TMDS_TERC4_EN
        de = 1'b0; island = 1'b1;
        for (int i = 0; i < 16; i++) begin
            aux = 4'(i); ctrl = 2'($urandom);
            tick();
            check($sformatf("terc4_%0h", i), bus.q_out, tb_terc[i]);
        end
        island = 1'b0;
`endif

        // Randomized run from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cnt = 0;
        rd = 0;
        for (int n = 0; n < 10000; n++) begin
            de = ($urandom % 6) != 0;
            data = 8'($urandom);
            ctrl = 2'($urandom);
`ifdef TMDS_TERC4_EN
            island = 1'($urandom);
            aux = 4'($urandom);
`endif
            model_step(exp_q);
            tick();
            check("rand_sym", bus.q_out, exp_q);
            if (de) begin
                check("rand_decode", {2'b00, decode(bus.q_out)}, {2'b00, data});
                rd += 2 * $countones(bus.q_out) - 10;
                tests++;
                if (rd > 10 || rd < -10) begin
                    fails++;
                    $display("FAIL rand_disparity: got %0d expected within +-10", rd);
                end
            end else begin
                rd = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
